// File: rtl/birukee_mm_seq_ctrl_if.sv
// Bundle of configuration, ESP DMA, systolic-macro and status signals
// seen by the birukee matrix-multiply sequencer.
interface birukee_mm_seq_ctrl_if #(
    parameter int N_W = 5
);
    logic           conf_done;
    logic [31:0]    conf_info_input1;
    logic [31:0]    conf_info_input2;
    logic [31:0]    conf_info_output;
    logic [31:0]    conf_info_size;

    logic           dma_read_ctrl_valid;
    logic           dma_read_ctrl_ready;
    logic [31:0]    dma_read_ctrl_data_index;
    logic [31:0]    dma_read_ctrl_data_length;
    logic [2:0]     dma_read_ctrl_data_size;
    logic           dma_read_chnl_valid;
    logic           dma_read_chnl_ready;
    logic [63:0]    dma_read_chnl_data;

    logic           dma_write_ctrl_valid;
    logic           dma_write_ctrl_ready;
    logic [31:0]    dma_write_ctrl_data_index;
    logic [31:0]    dma_write_ctrl_data_length;
    logic [2:0]     dma_write_ctrl_data_size;
    logic           dma_write_chnl_valid;
    logic           dma_write_chnl_ready;
    logic [63:0]    dma_write_chnl_data;

    logic [N_W-1:0] mm_size;
    logic           mm_a_valid;
    logic           mm_a_ready;
    logic           mm_b_valid;
    logic           mm_b_ready;
    logic [63:0]    mm_in_data;
    logic           mm_start;
    logic           mm_done;
    logic           mm_c_valid;
    logic           mm_c_ready;
    logic [63:0]    mm_c_data;

    logic           acc_done;
    logic [31:0]    debug;

    modport master (
        input  conf_done, conf_info_input1, conf_info_input2, conf_info_output, conf_info_size,
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
        output dma_read_ctrl_data_size,
        input  dma_read_ctrl_ready,
        input  dma_read_chnl_valid, dma_read_chnl_data,
        output dma_read_chnl_ready,
        output dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
        output dma_write_ctrl_data_size,
        input  dma_write_ctrl_ready,
        output dma_write_chnl_valid, dma_write_chnl_data,
        input  dma_write_chnl_ready,
        output mm_size, mm_a_valid, mm_b_valid, mm_in_data, mm_start, mm_c_ready,
        input  mm_a_ready, mm_b_ready, mm_done, mm_c_valid, mm_c_data,
        output acc_done, debug
    );

    modport slave (
        output conf_done, conf_info_input1, conf_info_input2, conf_info_output, conf_info_size,
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
        input  dma_read_ctrl_data_size,
        output dma_read_ctrl_ready,
        output dma_read_chnl_valid, dma_read_chnl_data,
        input  dma_read_chnl_ready,
        input  dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
        input  dma_write_ctrl_data_size,
        output dma_write_ctrl_ready,
        input  dma_write_chnl_valid, dma_write_chnl_data,
        output dma_write_chnl_ready,
        input  mm_size, mm_a_valid, mm_b_valid, mm_in_data, mm_start, mm_c_ready,
        output mm_a_ready, mm_b_ready, mm_done, mm_c_valid, mm_c_data,
        input  acc_done, debug
    );
endinterface

// File: rtl/birukee_mm_seq_ctrl.sv
// Sequencer for the birukee systolic matrix multiply: loads A then B over DMA,
// launches the macro, drains C back to DMA and pulses acc_done. Beats pass through.
module birukee_mm_seq_ctrl #(
    parameter int MAX_N = 16,
    parameter int N_W   = 5,
    parameter int CNT_W = 9
) (
    input logic                   clk,
    input logic                   rst,
    birukee_mm_seq_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_A_REQ = 4'd1,
        S_RD_A_DAT = 4'd2,
        S_RD_B_REQ = 4'd3,
        S_RD_B_DAT = 4'd4,
        S_COMP     = 4'd5,
        S_WAIT     = 4'd6,
        S_WR_REQ   = 4'd7,
        S_WR_DAT   = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t           state;
    logic             armed;
    logic             size_err;
    logic             rd_ctrl_valid;
    logic             wr_ctrl_valid;
    logic             start_q;
    logic             done_q;
    logic [N_W-1:0]   n_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      debug_q;
    logic [31:0]      idx_a;
    logic [31:0]      idx_b;
    logic [31:0]      idx_c;
    logic [31:0]      len;
    logic [2*N_W-1:0] sq;
    logic             in_a;
    logic             in_b;
    logic             in_c;
    logic             start_run;
    logic             size_bad;
    logic             rd_beat;
    logic             wr_beat;
    logic             beat_last;

    // Full 32-bit range check so oversize values never alias onto a small N.
    assign start_run = (state == S_IDLE) && bus.conf_done && armed;
    assign size_bad  = (bus.conf_info_size == 32'd0) || (bus.conf_info_size > 32'(MAX_N));

    assign sq        = {{N_W{1'b0}}, n_q} * {{N_W{1'b0}}, n_q};
    assign len       = 32'(sq);
    assign beat_last = ((2*N_W)'(cnt) + (2*N_W)'(1)) == sq;

    assign in_a    = (state == S_RD_A_DAT);
    assign in_b    = (state == S_RD_B_DAT);
    assign in_c    = (state == S_WR_DAT);
    assign rd_beat = bus.dma_read_chnl_valid && ((in_a && bus.mm_a_ready) || (in_b && bus.mm_b_ready));
    assign wr_beat = in_c && bus.mm_c_valid && bus.dma_write_chnl_ready;

    assign bus.dma_read_ctrl_valid        = rd_ctrl_valid;
    assign bus.dma_read_ctrl_data_index   = (state == S_RD_B_REQ) ? idx_b : idx_a;
    assign bus.dma_read_ctrl_data_length  = len;
    assign bus.dma_read_ctrl_data_size    = 3'b011;
    assign bus.dma_read_chnl_ready        = (in_a && bus.mm_a_ready) || (in_b && bus.mm_b_ready);
    assign bus.mm_a_valid                 = in_a && bus.dma_read_chnl_valid;
    assign bus.mm_b_valid                 = in_b && bus.dma_read_chnl_valid;
    assign bus.mm_in_data                 = bus.dma_read_chnl_data;

    assign bus.dma_write_ctrl_valid       = wr_ctrl_valid;
    assign bus.dma_write_ctrl_data_index  = idx_c;
    assign bus.dma_write_ctrl_data_length = len;
    assign bus.dma_write_ctrl_data_size   = 3'b011;
    assign bus.dma_write_chnl_valid       = in_c && bus.mm_c_valid;
    assign bus.mm_c_ready                 = in_c && bus.dma_write_chnl_ready;
    assign bus.dma_write_chnl_data        = bus.mm_c_data;

    assign bus.mm_size  = n_q;
    assign bus.mm_start = start_q;
    assign bus.acc_done = done_q;
    assign bus.debug    = debug_q;

    // Descriptor indices are plain data and need no reset.
    always_ff @(posedge clk) begin
        if (start_run) begin
            idx_a <= bus.conf_info_input1;
            idx_b <= bus.conf_info_input2;
            idx_c <= bus.conf_info_output;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            armed         <= 1'b1;
            size_err      <= 1'b0;
            rd_ctrl_valid <= 1'b0;
            wr_ctrl_valid <= 1'b0;
            start_q       <= 1'b0;
            done_q        <= 1'b0;
            n_q           <= '0;
            cnt           <= '0;
            debug_q       <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (!bus.conf_done) begin
                armed <= 1'b1;
            end

            debug_q              <= '0;
            debug_q[3:0]         <= state;
            debug_q[4]           <= size_err;
            debug_q[5]           <= armed;
            debug_q[16 +: CNT_W] <= cnt;

            case (state)
                S_IDLE: begin
                    if (start_run) begin
                        armed    <= 1'b0;
                        cnt      <= '0;
                        n_q      <= bus.conf_info_size[N_W-1:0];
                        size_err <= size_bad;
                        if (size_bad) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state         <= S_RD_A_REQ;
                            rd_ctrl_valid <= 1'b1;
                        end
                    end
                end
                S_RD_A_REQ: begin
                    if (bus.dma_read_ctrl_ready) begin
                        rd_ctrl_valid <= 1'b0;
                        state         <= S_RD_A_DAT;
                    end
                end
                S_RD_A_DAT: begin
                    if (rd_beat) begin
                        if (beat_last) begin
                            cnt           <= '0;
                            rd_ctrl_valid <= 1'b1;
                            state         <= S_RD_B_REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_RD_B_REQ: begin
                    if (bus.dma_read_ctrl_ready) begin
                        rd_ctrl_valid <= 1'b0;
                        state         <= S_RD_B_DAT;
                    end
                end
                S_RD_B_DAT: begin
                    if (rd_beat) begin
                        if (beat_last) begin
                            cnt     <= '0;
                            start_q <= 1'b1;
                            state   <= S_COMP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                // A level mm_done left over from a previous run must not skip the compute.
                S_COMP: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.mm_done) begin
                        wr_ctrl_valid <= 1'b1;
                        state         <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (bus.dma_write_ctrl_ready) begin
                        wr_ctrl_valid <= 1'b0;
                        state         <= S_WR_DAT;
                    end
                end
                S_WR_DAT: begin
                    if (wr_beat) begin
                        if (beat_last) begin
                            cnt    <= '0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_birukee_mm_seq_ctrl.sv
// Bench for birukee_mm_seq_ctrl: DMA/macro responders, descriptor and beat
// scoreboards, a table of run configurations and hand-written corner sequences.
module tb_birukee_mm_seq_ctrl;
    localparam int MAX_N = 16;
    localparam int N_W   = 5;
    localparam int CNT_W = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    birukee_mm_seq_ctrl_if #(.N_W(N_W)) bus ();
    birukee_mm_seq_ctrl #(.MAX_N(MAX_N), .N_W(N_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] index;
        logic [31:0] length;
    } desc_t;

    typedef struct {
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          rd_dly;
        bit          a_tog;
        bit          hold;
        int          wr_stall;
        bit          err;
    } vec_t;

    vec_t        vecs[8];
    desc_t       desc_q[$];
    logic [64:0] rd_exp_q[$];
    logic [63:0] c_exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int rd_dly, rd_wait, rd_left, rd_idx, rd_tag, rd_desc_n;
    int comp_cnt, c_left, c_idx, wr_stall_cfg, wr_stall;
    bit a_toggle, phase, hold_done, prev_wait;
    logic [31:0] prev_idx, prev_len;
    int a_beats, b_beats, c_beats, n_start, n_acc, rd_hold_total, c_at_acc;
    int cur_n, cur_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic env_clear();
        desc_q.delete();
        rd_exp_q.delete();
        c_exp_q.delete();
        rd_wait = 0; rd_left = 0; rd_idx = 0; rd_desc_n = 0;
        comp_cnt = 0; c_left = 0; c_idx = 0; wr_stall = 0;
        prev_wait = 1'b0; phase = 1'b0;
        a_beats = 0; b_beats = 0; c_beats = 0; n_start = 0; n_acc = 0;
        rd_hold_total = 0; c_at_acc = -1;
    endtask

    task automatic drive();
        bus.dma_read_ctrl_ready  = bus.dma_read_ctrl_valid && (rd_wait >= rd_dly);
        bus.dma_read_chnl_valid  = (rd_left > 0);
        bus.dma_read_chnl_data   = {32'(rd_tag), 32'(rd_idx)};
        phase                    = ~phase;
        bus.mm_a_ready           = a_toggle ? phase : 1'b1;
        bus.mm_b_ready           = 1'b1;
        bus.dma_write_ctrl_ready = 1'b1;
        bus.mm_done              = hold_done || (comp_cnt == 1);
        if (comp_cnt > 0) comp_cnt--;
        bus.mm_c_valid           = (c_left > 0);
        bus.mm_c_data            = 64'hC0DE_0000_0000_0000 | 64'(c_idx);
        bus.dma_write_chnl_ready = (wr_stall == 0);
        if (wr_stall > 0) wr_stall--;
    endtask

    task automatic pop_desc(input bit is_wr, input logic [31:0] idx, input logic [31:0] len,
                            input logic [2:0] sz);
        desc_t d;
        if (desc_q.size() == 0) begin
            chk(is_wr ? "wr_desc_unexpected" : "rd_desc_unexpected", 64'(idx), 64'hFFFF_FFFF);
        end else begin
            d = desc_q.pop_front();
            chk(is_wr ? "wr_desc_kind" : "rd_desc_kind", 64'(is_wr), 64'(d.is_wr));
            chk(is_wr ? "wr_desc_index" : "rd_desc_index", 64'(idx), 64'(d.index));
            chk(is_wr ? "wr_desc_length" : "rd_desc_length", 64'(len), 64'(d.length));
            chk(is_wr ? "wr_desc_size" : "rd_desc_size", 64'(sz), 64'd3);
        end
    endtask

    task automatic monitor();
        logic [64:0] e;
        bit dma_hs, a_hs, b_hs, w_hs, c_hs;
        if (bus.dma_read_ctrl_valid) begin
            if (prev_wait) begin
                chk("rd_desc_stable_index", 64'(bus.dma_read_ctrl_data_index), 64'(prev_idx));
                chk("rd_desc_stable_length", 64'(bus.dma_read_ctrl_data_length), 64'(prev_len));
            end
            if (bus.dma_read_ctrl_ready) begin
                pop_desc(1'b0, bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length,
                         bus.dma_read_ctrl_data_size);
                chk("mm_size", 64'(bus.mm_size), 64'(cur_n));
                prev_wait = 1'b0;
                rd_wait   = 0;
                rd_tag++;
                rd_left = cur_len;
                rd_idx  = 0;
                for (int i = 0; i < cur_len; i++)
                    rd_exp_q.push_back({1'(rd_desc_n == 1), 32'(rd_tag), 32'(i)});
                rd_desc_n++;
            end else begin
                prev_wait = 1'b1;
                prev_idx  = bus.dma_read_ctrl_data_index;
                prev_len  = bus.dma_read_ctrl_data_length;
                rd_wait++;
                rd_hold_total++;
            end
        end else begin
            prev_wait = 1'b0;
        end

        dma_hs = bus.dma_read_chnl_valid && bus.dma_read_chnl_ready;
        a_hs   = bus.mm_a_valid && bus.mm_a_ready;
        b_hs   = bus.mm_b_valid && bus.mm_b_ready;
        if (dma_hs || a_hs || b_hs) begin
            chk("rd_passthrough_hs", 64'(a_hs || b_hs), 64'(dma_hs));
            chk("rd_ab_exclusive", 64'(a_hs && b_hs), 64'd0);
            if (rd_exp_q.size() == 0) begin
                chk("rd_beat_unexpected", bus.mm_in_data, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = rd_exp_q.pop_front();
                chk("rd_stream_is_b", 64'(b_hs), 64'(e[64]));
                chk("rd_beat_data", bus.mm_in_data, e[63:0]);
            end
            if (a_hs) a_beats++;
            if (b_hs) b_beats++;
        end
        if (dma_hs) begin
            rd_left--;
            rd_idx++;
        end

        if (bus.mm_start) begin
            n_start++;
            comp_cnt = 4;
            c_left   = cur_len;
            c_idx    = 0;
            for (int i = 0; i < cur_len; i++)
                c_exp_q.push_back(64'hC0DE_0000_0000_0000 | 64'(i));
        end

        if (bus.dma_write_ctrl_valid && bus.dma_write_ctrl_ready) begin
            pop_desc(1'b1, bus.dma_write_ctrl_data_index, bus.dma_write_ctrl_data_length,
                     bus.dma_write_ctrl_data_size);
            wr_stall = wr_stall_cfg;
        end

        w_hs = bus.dma_write_chnl_valid && bus.dma_write_chnl_ready;
        c_hs = bus.mm_c_valid && bus.mm_c_ready;
        if (w_hs || c_hs) begin
            chk("wr_passthrough_hs", 64'(w_hs), 64'(c_hs));
            if (c_exp_q.size() == 0)
                chk("wr_beat_unexpected", bus.dma_write_chnl_data, 64'hFFFF_FFFF_FFFF_FFFF);
            else
                chk("wr_beat_data", bus.dma_write_chnl_data, c_exp_q.pop_front());
            c_beats++;
        end
        if (c_hs) begin
            c_left--;
            c_idx++;
        end

        if (bus.acc_done) begin
            n_acc++;
            c_at_acc = c_beats;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        monitor();
    endtask

    task automatic setup_run(input vec_t v);
        env_clear();
        cur_n        = v.n;
        cur_len      = v.err ? 0 : v.n * v.n;
        rd_dly       = v.rd_dly;
        a_toggle     = v.a_tog;
        hold_done    = v.hold;
        wr_stall_cfg = v.wr_stall;
        if (!v.err) begin
            desc_q.push_back('{1'b0, v.a, 32'(cur_len)});
            desc_q.push_back('{1'b0, v.b, 32'(cur_len)});
            desc_q.push_back('{1'b1, v.c, 32'(cur_len)});
        end
        bus.conf_info_input1 = v.a;
        bus.conf_info_input2 = v.b;
        bus.conf_info_output = v.c;
        bus.conf_info_size   = 32'(v.n);
    endtask

    task automatic run_case(input vec_t v, input string tag);
        int lat;
        setup_run(v);
        bus.conf_done = 1'b1;
        tick();
        bus.conf_done = 1'b0;
        lat = 1;
        while (n_acc == 0 && lat < 2000) begin
            tick();
            lat++;
        end
        repeat (3) tick();
        if (n_acc == 0) $display("FAIL %s_timeout: no acc_done after %0d cycles, expected one", tag, lat);
        chk({tag, "_acc_count"}, 64'(n_acc), 64'd1);
        chk({tag, "_start_count"}, 64'(n_start), v.err ? 64'd0 : 64'd1);
        chk({tag, "_a_beats"}, 64'(a_beats), 64'(cur_len));
        chk({tag, "_b_beats"}, 64'(b_beats), 64'(cur_len));
        chk({tag, "_c_beats"}, 64'(c_beats), 64'(cur_len));
        chk({tag, "_total_hs"}, 64'(a_beats + b_beats + c_beats), 64'(3 * cur_len));
        chk({tag, "_c_beats_before_acc"}, 64'(c_at_acc), 64'(cur_len));
        chk({tag, "_desc_left"}, 64'(desc_q.size()), 64'd0);
        chk({tag, "_rd_hold_cycles"}, 64'(rd_hold_total), v.err ? 64'd0 : 64'(2 * v.rd_dly));
        chk({tag, "_debug_err"}, 64'(bus.debug[4]), 64'(v.err));
        chk({tag, "_debug_state_idle"}, 64'(bus.debug[3:0]), 64'd0);
        chk({tag, "_debug_armed"}, 64'(bus.debug[5]), 64'd1);
        if (v.err) chk({tag, "_err_latency_le2"}, 64'(lat <= 2 + 3), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{4,  32'h100, 32'h200, 32'h300, 0, 1'b0, 1'b0, 0,  1'b0};
        vecs[1] = '{2,  32'h040, 32'h080, 32'h0C0, 5, 1'b1, 1'b0, 0,  1'b0};
        vecs[2] = '{0,  32'h111, 32'h222, 32'h333, 0, 1'b0, 1'b0, 0,  1'b1};
        vecs[3] = '{17, 32'h111, 32'h222, 32'h333, 0, 1'b0, 1'b0, 0,  1'b1};
        vecs[4] = '{4,  32'h500, 32'h600, 32'h700, 0, 1'b0, 1'b1, 10, 1'b0};
        vecs[5] = '{16, 32'h1000, 32'h2000, 32'h3000, 2, 1'b1, 1'b0, 3, 1'b0};
        vecs[6] = '{1,  32'h010, 32'h020, 32'h030, 0, 1'b0, 1'b0, 0,  1'b0};
        vecs[7] = '{3,  32'h900, 32'hA00, 32'hB00, 0, 1'b0, 1'b0, 0,  1'b0};

        rd_tag = 0; rd_dly = 0; a_toggle = 1'b0; hold_done = 1'b0; wr_stall_cfg = 0;
        cur_n = 0; cur_len = 0;
        env_clear();
        bus.conf_done = 1'b0;
        bus.conf_info_input1 = '0; bus.conf_info_input2 = '0;
        bus.conf_info_output = '0; bus.conf_info_size = '0;
        bus.dma_read_ctrl_ready = 1'b0; bus.dma_read_chnl_valid = 1'b0;
        bus.dma_read_chnl_data = '0; bus.dma_write_ctrl_ready = 1'b0;
        bus.dma_write_chnl_ready = 1'b0; bus.mm_a_ready = 1'b0; bus.mm_b_ready = 1'b0;
        bus.mm_done = 1'b0; bus.mm_c_valid = 1'b0; bus.mm_c_data = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl_valids", 64'({bus.dma_read_ctrl_valid, bus.dma_write_ctrl_valid}), 64'd0);
        chk("reset_chnl_hs", 64'({bus.dma_read_chnl_ready, bus.dma_write_chnl_valid,
                                  bus.mm_a_valid, bus.mm_b_valid, bus.mm_c_ready}), 64'd0);
        chk("reset_pulses", 64'({bus.mm_start, bus.acc_done}), 64'd0);
        chk("reset_mm_size", 64'(bus.mm_size), 64'd0);
        chk("reset_debug", 64'(bus.debug), 64'd0);
        rst = 1'b0;
        repeat (2) tick();
        chk("post_reset_armed", 64'(bus.debug[5]), 64'd1);
        chk("post_reset_state", 64'(bus.debug[3:0]), 64'd0);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            run_case(v, $sformatf("vec%0d", i));
        end

        // conf_done held high: one run only, then re-arm for a second run
        setup_run(vecs[6]);
        bus.conf_done = 1'b1;
        repeat (100) tick();
        chk("held_acc_count", 64'(n_acc), 64'd1);
        chk("held_start_count", 64'(n_start), 64'd1);
        chk("held_c_beats", 64'(c_beats), 64'd1);
        chk("held_desc_left", 64'(desc_q.size()), 64'd0);
        chk("held_not_armed", 64'(bus.debug[5]), 64'd0);
        bus.conf_done = 1'b0;
        tick();
        run_case(vecs[6], "rearm");

        // Reset in the middle of the B load, then a clean run
        setup_run(vecs[7]);
        bus.conf_done = 1'b1;
        tick();
        bus.conf_done = 1'b0;
        for (int t = 0; t < 500 && b_beats < 3; t++) tick();
        chk("abort_reached_b3", 64'(b_beats), 64'd3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ctrl_valids", 64'({bus.dma_read_ctrl_valid, bus.dma_write_ctrl_valid}), 64'd0);
        chk("abort_chnl_hs", 64'({bus.dma_read_chnl_ready, bus.dma_write_chnl_valid,
                                  bus.mm_a_valid, bus.mm_b_valid, bus.mm_c_ready}), 64'd0);
        chk("abort_pulses", 64'({bus.mm_start, bus.acc_done}), 64'd0);
        chk("abort_mm_size", 64'(bus.mm_size), 64'd0);
        chk("abort_debug", 64'(bus.debug), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        env_clear();
        repeat (2) tick();
        run_case(vecs[7], "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
